// File: rtl/alu_exec_if.sv
// Handshake bus of the ALU execute stage: request side from decode and
// result side to the downstream consumer.
interface alu_exec_if;
    logic        valid_i;
    logic        ready_o;
    logic [3:0]  ALUCtl_i;
    logic [31:0] data1_i;
    logic [31:0] data2_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] data_o;
    logic        zero_o;
    logic        err_o;

    modport master (
        output valid_i, ALUCtl_i, data1_i, data2_i, ready_i,
        input  ready_o, valid_o, data_o, zero_o, err_o
    );

    modport slave (
        input  valid_i, ALUCtl_i, data1_i, data2_i, ready_i,
        output ready_o, valid_o, data_o, zero_o, err_o
    );
endinterface

// File: rtl/alu_exec.sv
// alu_exec: handshaked ALU execute stage with single-cycle ops and an optional
// 32-iteration shift-add multiplier enabled by the macro ALU_EXEC_MUL_EN.
module alu_exec (
    input  logic      clk_i,
    input  logic      rst_i,
    alu_exec_if.slave bus
);
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_XOR = 4'd3;
    localparam logic [3:0] OP_SLL = 4'd4;
    localparam logic [3:0] OP_SRA = 4'd5;
`ifdef ALU_EXEC_MUL_EN
    localparam logic [3:0] OP_MUL = 4'd6;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
`ifdef ALU_EXEC_MUL_EN
        BUSY = 2'd1,
`endif
        DONE = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic        accept;
    logic [31:0] alu_res;
    logic        alu_err;
    logic [31:0] data_q;
    logic        err_q;

`ifdef ALU_EXEC_MUL_EN
    logic [31:0] acc_q;
    logic [31:0] mcand_q;
    logic [31:0] mplier_q;
    logic [4:0]  cnt_q;
    logic [31:0] acc_d;

    // Only the low 32 product bits are kept, so a 32-bit accumulator suffices.
    assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif

    assign accept = bus.valid_i && bus.ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
`ifdef ALU_EXEC_MUL_EN
                    state_d = (bus.ALUCtl_i == OP_MUL) ? BUSY : DONE;
`else
                    state_d = DONE;
`endif
                end
            end
`ifdef ALU_EXEC_MUL_EN
            BUSY: begin
                if (cnt_q == 5'd31) begin
                    state_d = DONE;
                end
            end
`endif
            DONE: begin
                if (bus.ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.ready_o = (state_q == IDLE);
        bus.valid_o = (state_q == DONE);
        bus.data_o  = data_q;
        bus.err_o   = err_q;
        bus.zero_o  = (state_q == DONE) && (data_q == '0);
    end

    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        case (bus.ALUCtl_i)
            OP_ADD:  alu_res = bus.data1_i + bus.data2_i;
            OP_SUB:  alu_res = bus.data1_i - bus.data2_i;
            OP_AND:  alu_res = bus.data1_i & bus.data2_i;
            OP_XOR:  alu_res = bus.data1_i ^ bus.data2_i;
            OP_SLL:  alu_res = bus.data1_i << bus.data2_i[4:0];
            OP_SRA:  alu_res = $unsigned($signed(bus.data1_i) >>> bus.data2_i[4:0]);
`ifdef ALU_EXEC_MUL_EN
            OP_MUL:  alu_res = '0;
`endif
            default: alu_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q   <= '0;
            err_q    <= 1'b0;
`ifdef ALU_EXEC_MUL_EN
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
`endif
        end else if (accept) begin
            data_q   <= alu_res;
            err_q    <= alu_err;
`ifdef ALU_EXEC_MUL_EN
            acc_q    <= '0;
            mcand_q  <= bus.data1_i;
            mplier_q <= bus.data2_i;
            cnt_q    <= '0;
`endif
        end
`ifdef ALU_EXEC_MUL_EN
        else if (state_q == BUSY) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
                data_q <= acc_d;
            end
        end
`endif
    end
endmodule

// File: tb/tb_alu_exec.sv
// Scoreboard bench for alu_exec: driver pushes reference-model results,
// a negedge monitor pops and compares them on every handoff.
module tb_alu_exec;
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_XOR = 4'd3;
    localparam logic [3:0] OP_SLL = 4'd4;
    localparam logic [3:0] OP_SRA = 4'd5;
    localparam logic [3:0] OP_MUL = 4'd6;

    typedef struct {
        logic [31:0] data;
        logic        zero;
        logic        err;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass = 0;
    bit   rand_rdy = 1'b0;
    exp_t exp_q[$];

    int   mon_lat = 0;
    bit   mon_seen = 1'b0;
    exp_t mon_e;

    alu_exec_if bus ();

    alu_exec dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Reference model straight from the operation definitions.
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int unsigned sh;
        logic [63:0] p;
        sh = b % 32;
        e.data = '0;
        e.err = 1'b0;
        e.lat = 1;
        case (op)
            OP_ADD: e.data = a + b;
            OP_SUB: e.data = a - b;
            OP_AND: e.data = a & b;
            OP_XOR: e.data = a ^ b;
            OP_SLL: e.data = a << sh;
            OP_SRA: e.data = a[31] ? ~((~a) >> sh) : (a >> sh);
`ifdef ALU_EXEC_MUL_EN
            OP_MUL: begin
                p = {32'd0, a} * {32'd0, b};
                e.data = p[31:0];
                e.lat = 33;
            end
`endif
            default: e.err = 1'b1;
        endcase
        e.zero = (e.data == 32'd0);
        return e;
    endfunction

    // Called at posedge+1; returns at posedge+1 of the cycle after the accept.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int unsigned guard;
        guard = 0;
        while (!bus.ready_o && guard < 200) begin
            guard++;
            @(posedge clk); #1;
        end
        if (!bus.ready_o) begin
            check("issue_ready_timeout", {31'd0, bus.ready_o}, 32'd1);
        end else begin
            bus.valid_i  = 1'b1;
            bus.ALUCtl_i = op;
            bus.data1_i  = a;
            bus.data2_i  = b;
            exp_q.push_back(model(op, a, b));
            @(posedge clk); #1;
            bus.valid_i  = 1'b0;
            bus.ALUCtl_i = 4'($urandom_range(0, 15));
            bus.data1_i  = $urandom;
            bus.data2_i  = $urandom;
        end
    endtask

    task automatic wait_idle();
        int unsigned guard;
        guard = 0;
        while ((exp_q.size() != 0 || !bus.ready_o) && guard < 300) begin
            guard++;
            @(posedge clk); #1;
        end
        check("drain_timeout", {31'd0, (exp_q.size() == 0 && bus.ready_o)}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, {31'd0, bus.ready_o}, 32'd1);
        check({tag, "_valid"}, {31'd0, bus.valid_o}, 32'd0);
        check({tag, "_data"},  bus.data_o, 32'd0);
        check({tag, "_zero"},  {31'd0, bus.zero_o}, 32'd0);
        check({tag, "_err"},   {31'd0, bus.err_o}, 32'd0);
    endtask

    // Monitor: latency from accept to first valid, held values while valid, pop on handoff.
    initial begin
        forever begin
            @(negedge clk);
            mon_lat++;
            if (!rst && bus.valid_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", {31'd0, bus.valid_o}, 32'd0);
                end else begin
                    mon_e = exp_q[0];
                    check("data", bus.data_o, mon_e.data);
                    check("zero", {31'd0, bus.zero_o}, {31'd0, mon_e.zero});
                    check("err",  {31'd0, bus.err_o},  {31'd0, mon_e.err});
                    check("ready_in_done", {31'd0, bus.ready_o}, 32'd0);
                    if (!mon_seen) check("latency", mon_lat, mon_e.lat);
                    mon_seen = 1'b1;
                    if (bus.ready_i) begin
                        void'(exp_q.pop_front());
                        mon_seen = 1'b0;
                    end
                end
            end
            if (rst) mon_seen = 1'b0;
            if (bus.valid_i && bus.ready_o && !rst) mon_lat = 0;
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_rdy) bus.ready_i = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned cnt;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;

        bus.valid_i  = 1'b0;
        bus.ready_i  = 1'b1;
        bus.ALUCtl_i = '0;
        bus.data1_i  = '0;
        bus.data2_i  = '0;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        issue(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
        issue(OP_SUB, 32'd5, 32'd5);
        issue(OP_SRA, 32'h8000_0000, 32'h0000_003F);
        issue(OP_SRA, 32'h7000_0000, 32'h0000_001F);
        issue(OP_SLL, 32'h1234_5678, 32'h0000_0000);
        issue(OP_SLL, 32'h1234_5678, 32'h0000_0020);
        issue(4'b1111, 32'd1, 32'd1);
        wait_idle();

        // Multiply: ready_o stays low through BUSY plus the DONE cycle.
        issue(OP_MUL, 32'h0001_0003, 32'h0002_0005);
        cnt = 0;
        while (!bus.ready_o && cnt < 100) begin
            cnt++;
            @(posedge clk); #1;
        end
`ifdef ALU_EXEC_MUL_EN
        check("mul_ready_low_cycles", cnt, 32'd33);
`else
        check("mul_ready_low_cycles", cnt, 32'd1);
`endif
        wait_idle();

        // Backpressure: inputs toggled and valid_i held high while the result waits.
        bus.ready_i = 1'b0;
        issue(OP_ADD, 32'd1, 32'd2);
        for (int j = 0; j < 10; j++) begin
            bus.valid_i  = 1'b1;
            bus.ALUCtl_i = 4'($urandom_range(0, 15));
            bus.data1_i  = $urandom;
            bus.data2_i  = $urandom;
            check("bp_ready", {31'd0, bus.ready_o}, 32'd0);
            check("bp_data", bus.data_o, 32'd3);
            @(posedge clk); #1;
        end
        bus.ready_i = 1'b1;
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
        check("bp_idle_ready", {31'd0, bus.ready_o}, 32'd1);
        check("bp_idle_valid", {31'd0, bus.valid_o}, 32'd0);
        wait_idle();

        // Reset on the 10th cycle of a multiply, with a request offered alongside.
        bus.ready_i = 1'b0;
        issue(OP_MUL, 32'hDEAD_BEEF, 32'h0000_1234);
        repeat (9) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        bus.valid_i  = 1'b1;
        bus.ALUCtl_i = OP_ADD;
        bus.data1_i  = 32'd7;
        bus.data2_i  = 32'd8;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.valid_i = 1'b0;
        exp_q.delete();
        check_reset_outputs("mul_reset");
        bus.ready_i = 1'b1;
        cnt = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.valid_o) cnt++;
        end
        check("post_reset_valid_cycles", cnt, 32'd0);

        // Randomized traffic with random downstream backpressure.
        rand_rdy = 1'b1;
        for (int i = 0; i < 200; i++) begin
            op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 6));
            case ($urandom_range(0, 3))
                0: a = 32'd0;
                1: a = 32'hFFFF_FFFF;
                default: a = $urandom;
            endcase
            b = ($urandom_range(0, 4) == 0) ? a : $urandom;
            issue(op, a, b);
        end
        rand_rdy = 1'b0;
        bus.ready_i = 1'b1;
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 The block SHALL have these ports:
- clk_i  input  1  single clock; all state updates on rising edge.
- rst_i  input  1  reset, synchronous, active-high.
- valid_i  input  1  request valid from decode stage.
- ready_o  output  1  block can accept a request.
- ALUCtl_i  input  4  operation code from ALU_CTL_* in Const.v.
- data1_i  input  32  operand 1.
- data2_i  input  32  operand 2.
- valid_o  output  1  result valid.
- ready_i  input  1  downstream accepts result.
- data_o  output  32  result.
- zero_o  output  1  high when data_o is 0.
- err_o  output  1  accepted code was unsupported.
REQ-002 The block SHALL use one clock, clk_i; reset SHALL be rst_i, synchronous and active-high.

Function
REQ-003 The FSM SHALL have three states:
- IDLE: ready_o=1, valid_o=0.
- BUSY: multiply iterating, ready_o=0, valid_o=0.
- DONE: ready_o=0, valid_o=1.
REQ-004 A request SHALL be accepted on a rising edge where valid_i && ready_o; ALUCtl_i, data1_i and data2_i SHALL be captured at that edge, and later input changes SHALL be ignored until the next accept.
REQ-005 Single-cycle operations SHALL go IDLE -> DONE, with valid_o high on the cycle after the accept (latency 1):
- ADD: data1+data2, mod 2^32.
- SUB: data1-data2, mod 2^32.
- AND: bitwise.
- XOR: bitwise.
- SLL: data1 << data2[4:0].
- SRA: arithmetic data1 >>> data2[4:0].
REQ-006 MUL SHALL go IDLE -> BUSY, perform 32 shift-add iterations (one per cycle), then go to DONE; data_o SHALL be the low 32 bits of the unsigned product, and valid_o SHALL rise 33 cycles after the accept.
REQ-007 An unsupported ALUCtl_i SHALL complete as a single-cycle operation with data_o=0 and err_o=1; err_o SHALL be 0 for every supported code.
REQ-008 In DONE, data_o, zero_o and err_o SHALL hold stable until valid_o && ready_i; on that edge the FSM SHALL return to IDLE.
REQ-009 No new request SHALL be accepted in DONE, even on the handoff cycle; the next accept is possible one cycle after the handoff at the earliest.
REQ-010 zero_o SHALL equal (data_o == 0) whenever valid_o=1, and SHALL be 0 otherwise.
REQ-011 Shift amounts SHALL use data2[4:0] only: SLL by 0 returns data1, and SRA by 31 returns all-ones or all-zeros depending on data1[31].
REQ-012 ready_i SHALL be ignored when valid_o=0, and valid_i SHALL be ignored when ready_o=0.

Reset
REQ-013 While rst_i=1 at a clock edge, the FSM SHALL enter IDLE and the outputs SHALL be: ready_o=1, valid_o=0, data_o=0, zero_o=0, err_o=0.
REQ-014 A reset during BUSY or DONE SHALL discard the partial or pending result, and no valid_o pulse SHALL follow.
REQ-015 A request with valid_i=1 in the same cycle as rst_i=1 SHALL NOT be accepted.

Configuration
REQ-016 The macro ALU_EXEC_MUL_EN SHALL control multiply support:
- Defined: MUL behaves per REQ-006, using the BUSY state.
- Undefined: the MUL code is treated as unsupported per REQ-007 (1-cycle, data_o=0, err_o=1), and the BUSY state and multiplier datapath are not synthesized.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
- ADD 0x7FFFFFFF + 0x00000001, ready_i=1 -> valid_o one cycle after accept, data_o=0x80000000, zero_o=0, err_o=0.
- SUB 5 - 5 -> data_o=0, zero_o=1; SRA 0x80000000 by 0x3F -> data_o=0xFFFFFFFF (shift by 31).
- MUL 0x00010003 * 0x00020005 with ALU_EXEC_MUL_EN defined -> ready_o low 33 cycles, valid_o at cycle 33, data_o=0x000B000F (low 32 bits of 0x2000B000F). Without the macro -> data_o=0, err_o=1 after 1 cycle.
- Backpressure: ADD 1+2 with ready_i=0 for 10 cycles, operand inputs toggled meanwhile -> data_o holds 3 and ready_o=0 throughout; handoff on ready_i=1, then IDLE.
- Reset on the 10th cycle of a MUL -> next cycle IDLE, all outputs at reset values, no valid_o afterwards.
- Unsupported code 4'b1111 with operands 1, 1 -> data_o=0, err_o=1, zero_o=1.
